frame_stream_checker: RTL and testbench

- Synthesizable, parametrised successor to the golden-frame compare currently done offline after the RGB565 output buffer fills.
- Compares a live pixel stream, sitting on the converter-to-output-buffer path, against expected pixels fetched from a golden ROM.
- Counts mismatches and captures the first failing pixel with its coordinates.
- Raises a one-cycle done/pass verdict per frame, so the comparison runs in hardware without a full-frame memory dump.

---
 rtl/frame_stream_checker.sv | 226 ++++++++++++++++++++++
 tb/tb_frame_stream_checker.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/frame_stream_checker.sv
// frame_stream_checker: compares a live pixel stream against a golden ROM,
// counts mismatches (saturating), captures the first failing pixel and issues
// a one-cycle done/pass verdict per frame.
// Optional macro FRAME_CRC_EN: when defined, oCrc carries a CRC-32 signature
// of the masked received pixels; when undefined, oCrc is tied to zero.
module frame_stream_checker #(
  parameter int PIX_W   = 16,
  parameter int FRAME_W = 480,
  parameter int FRAME_H = 272,
  parameter int ADDR_W  = 17,
  parameter int ERR_W   = 17
) (
  input  logic              iClk,
  input  logic              iRsn,
  input  logic              iStart,
  input  logic [PIX_W-1:0]  iMask,
  input  logic              iPixValid,
  input  logic [PIX_W-1:0]  iPixData,
  output logic              oPixReady,
  output logic              oExpRd,
  output logic [ADDR_W-1:0] oExpAddr,
  input  logic [PIX_W-1:0]  iExpData,
  output logic              oBusy,
  output logic              oDone,
  output logic              oPass,
  output logic [ERR_W-1:0]  oErrCnt,
  output logic [ADDR_W-1:0] oFirstErrIdx,
  output logic [ADDR_W-1:0] oFirstErrX,
  output logic [ADDR_W-1:0] oFirstErrY,
  output logic [PIX_W-1:0]  oFirstErrExp,
  output logic [PIX_W-1:0]  oFirstErrGot,
  output logic [31:0]       oCrc
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_W * FRAME_H - 1);
  localparam logic [ADDR_W-1:0] LAST_X   = ADDR_W'(FRAME_W - 1);
  localparam logic [ERR_W-1:0]  ERR_MAX  = {ERR_W{1'b1}};

  logic [1:0]        state_r, state_s;
  logic [ADDR_W-1:0] idx_r, x_r, y_r;
  logic [PIX_W-1:0]  mask_r;
  logic              cmp_valid_r;
  logic [PIX_W-1:0]  got_r;
  logic [ADDR_W-1:0] cmp_idx_r, cmp_x_r, cmp_y_r;
  logic [ERR_W-1:0]  err_cnt_r;
  logic              first_seen_r;
  logic [ADDR_W-1:0] first_idx_r, first_x_r, first_y_r;
  logic [PIX_W-1:0]  first_exp_r, first_got_r;
  logic              done_r, pass_r;
  logic              accept_s, start_s, mismatch_s, finish_s;

  // Handshake, restart qualification and the masked compare of the pipeline stage.
  always_comb begin
    accept_s   = iPixValid && (state_r == ST_RUN);
    start_s    = iStart && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    finish_s   = (state_r == ST_DRAIN) && !cmp_valid_r;
    mismatch_s = cmp_valid_r && (((got_r ^ iExpData) & mask_r) != {PIX_W{1'b0}});
  end

  // Next-state logic; DRAIN waits until the last compare has been counted.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:  if (start_s) state_s = ST_RUN; else state_s = ST_IDLE;
      ST_RUN:   if (accept_s && (idx_r == LAST_IDX)) state_s = ST_DRAIN; else state_s = ST_RUN;
      ST_DRAIN: if (!cmp_valid_r) state_s = ST_DONE; else state_s = ST_DRAIN;
      ST_DONE:  if (start_s) state_s = ST_RUN; else state_s = ST_DONE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) state_r <= ST_IDLE;
    else       state_r <= state_s;
  end

  // Pixel index and raster position; stalls simply hold them.
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      idx_r <= {ADDR_W{1'b0}};
      x_r   <= {ADDR_W{1'b0}};
      y_r   <= {ADDR_W{1'b0}};
    end else if (start_s) begin
      idx_r <= {ADDR_W{1'b0}};
      x_r   <= {ADDR_W{1'b0}};
      y_r   <= {ADDR_W{1'b0}};
    end else if (accept_s) begin
      idx_r <= idx_r + ADDR_W'(1);
      if (x_r == LAST_X) begin
        x_r <= {ADDR_W{1'b0}};
        y_r <= y_r + ADDR_W'(1);
      end else begin
        x_r <= x_r + ADDR_W'(1);
      end
    end else begin
      idx_r <= idx_r;
    end
  end

  // Compare mask is frozen for the whole frame.
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn)        mask_r <= {PIX_W{1'b0}};
    else if (start_s) mask_r <= iMask;
    else              mask_r <= mask_r;
  end

  // Compare stage: hold the received pixel and its position until the ROM answers.
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      cmp_valid_r <= 1'b0;
      got_r       <= {PIX_W{1'b0}};
      cmp_idx_r   <= {ADDR_W{1'b0}};
      cmp_x_r     <= {ADDR_W{1'b0}};
      cmp_y_r     <= {ADDR_W{1'b0}};
    end else begin
      cmp_valid_r <= accept_s;
      if (accept_s) begin
        got_r     <= iPixData;
        cmp_idx_r <= idx_r;
        cmp_x_r   <= x_r;
        cmp_y_r   <= y_r;
      end else begin
        got_r     <= got_r;
      end
    end
  end

  // Saturating error counter and first-mismatch capture.
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      err_cnt_r    <= {ERR_W{1'b0}};
      first_seen_r <= 1'b0;
      first_idx_r  <= {ADDR_W{1'b0}};
      first_x_r    <= {ADDR_W{1'b0}};
      first_y_r    <= {ADDR_W{1'b0}};
      first_exp_r  <= {PIX_W{1'b0}};
      first_got_r  <= {PIX_W{1'b0}};
    end else if (start_s) begin
      err_cnt_r    <= {ERR_W{1'b0}};
      first_seen_r <= 1'b0;
      first_idx_r  <= {ADDR_W{1'b0}};
      first_x_r    <= {ADDR_W{1'b0}};
      first_y_r    <= {ADDR_W{1'b0}};
      first_exp_r  <= {PIX_W{1'b0}};
      first_got_r  <= {PIX_W{1'b0}};
    end else if (mismatch_s) begin
      if (err_cnt_r != ERR_MAX) err_cnt_r <= err_cnt_r + ERR_W'(1);
      else                      err_cnt_r <= err_cnt_r;
      if (!first_seen_r) begin
        first_seen_r <= 1'b1;
        first_idx_r  <= cmp_idx_r;
        first_x_r    <= cmp_x_r;
        first_y_r    <= cmp_y_r;
        first_exp_r  <= iExpData;
        first_got_r  <= got_r;
      end else begin
        first_seen_r <= first_seen_r;
      end
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  // Verdict: one-cycle done pulse on entry to DONE, pass held until restart.
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      done_r <= 1'b0;
      pass_r <= 1'b0;
    end else begin
      done_r <= finish_s;
      if (start_s)       pass_r <= 1'b0;
      else if (finish_s) pass_r <= (err_cnt_r == {ERR_W{1'b0}});
      else               pass_r <= pass_r;
    end
  end

`ifdef FRAME_CRC_EN
  logic [31:0] crc_r;

  // One CRC-32 step over a whole pixel, MSB first, polynomial 0x04C11DB7.
  function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [PIX_W-1:0] data);
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int i = PIX_W - 1; i >= 0; i--) begin
      fb = c[31] ^ data[i];
      c  = {c[30:0], 1'b0};
      if (fb) c = c ^ 32'h04C1_1DB7;
      else    c = c;
    end
    return c;
  endfunction

  // Frame signature over the masked received pixels.
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn)         crc_r <= 32'h0000_0000;
    else if (start_s)  crc_r <= 32'hFFFF_FFFF;
    else if (accept_s) crc_r <= crc_step(crc_r, iPixData & mask_r);
    else               crc_r <= crc_r;
  end

  assign oCrc = crc_r;
`else
  assign oCrc = 32'h0000_0000;
`endif

  assign oPixReady    = (state_r == ST_RUN);
  assign oBusy        = (state_r == ST_RUN) || (state_r == ST_DRAIN);
  assign oExpRd       = accept_s;
  assign oExpAddr     = idx_r;
  assign oDone        = done_r;
  assign oPass        = pass_r;
  assign oErrCnt      = err_cnt_r;
  assign oFirstErrIdx = first_idx_r;
  assign oFirstErrX   = first_x_r;
  assign oFirstErrY   = first_y_r;
  assign oFirstErrExp = first_exp_r;
  assign oFirstErrGot = first_got_r;

endmodule

// File: tb/tb_frame_stream_checker.sv
// Scoreboard bench for frame_stream_checker on a 4x2 frame with golden ROM[i]=16'h1000+i.
// A second instance with ERR_W=2 shares the stimulus to exercise counter saturation.
module tb_frame_stream_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, pix_valid;
  logic [15:0] mask, pix_data, exp_data;

  logic        pix_ready, exp_rd, busy, done, pass;
  logic [16:0] exp_addr, err_cnt, fidx, fx, fy;
  logic [15:0] fexp, fgot;
  logic [31:0] crc;

  logic        s_pix_ready, s_exp_rd, s_busy, s_done, s_pass;
  logic [16:0] s_exp_addr, s_fidx, s_fx, s_fy;
  logic [1:0]  s_err_cnt;
  logic [15:0] s_fexp, s_fgot;
  logic [31:0] s_crc;

  frame_stream_checker #(.PIX_W(16), .FRAME_W(4), .FRAME_H(2), .ADDR_W(17), .ERR_W(17)) dut (
    .iClk(clk), .iRsn(rst_n), .iStart(start), .iMask(mask), .iPixValid(pix_valid),
    .iPixData(pix_data), .oPixReady(pix_ready), .oExpRd(exp_rd), .oExpAddr(exp_addr),
    .iExpData(exp_data), .oBusy(busy), .oDone(done), .oPass(pass), .oErrCnt(err_cnt),
    .oFirstErrIdx(fidx), .oFirstErrX(fx), .oFirstErrY(fy), .oFirstErrExp(fexp),
    .oFirstErrGot(fgot), .oCrc(crc));

  frame_stream_checker #(.PIX_W(16), .FRAME_W(4), .FRAME_H(2), .ADDR_W(17), .ERR_W(2)) dut_sat (
    .iClk(clk), .iRsn(rst_n), .iStart(start), .iMask(mask), .iPixValid(pix_valid),
    .iPixData(pix_data), .oPixReady(s_pix_ready), .oExpRd(s_exp_rd), .oExpAddr(s_exp_addr),
    .iExpData(exp_data), .oBusy(s_busy), .oDone(s_done), .oPass(s_pass), .oErrCnt(s_err_cnt),
    .oFirstErrIdx(s_fidx), .oFirstErrX(s_fx), .oFirstErrY(s_fy), .oFirstErrExp(s_fexp),
    .oFirstErrGot(s_fgot), .oCrc(s_crc));

  // Golden ROM model: data valid one cycle after the read strobe.
  always @(posedge clk) begin
    if (exp_rd) exp_data <= 16'h1000 + exp_addr[15:0];
  end

  typedef struct {
    logic        pass;
    logic [16:0] err;
    logic [1:0]  err_sat;
    logic [16:0] idx, x, y;
    logic [15:0] e, g;
    logic [31:0] crc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, req);
    end
  endtask

  function automatic exp_t mk(input logic p, input logic [16:0] err, input logic [1:0] sat,
                              input logic [16:0] idx, input logic [16:0] x, input logic [16:0] y,
                              input logic [15:0] e, input logic [15:0] g);
    exp_t r;
    r.pass = p; r.err = err; r.err_sat = sat; r.idx = idx; r.x = x; r.y = y;
    r.e = e; r.g = g; r.crc = 32'h0;
    return r;
  endfunction

  // Reference CRC-32 (poly 04C11DB7, init FFFFFFFF, MSB first, no reflection/xorout).
  function automatic logic [31:0] crc_model(input logic [7:0][15:0] p, input logic [15:0] m);
    logic [31:0] c;
    logic [15:0] d;
    c = 32'hFFFF_FFFF;
    for (int k = 0; k < 8; k++) begin
      d = p[k] & m;
      for (int b = 15; b >= 0; b--) begin
        if (c[31] ^ d[b]) c = {c[30:0], 1'b0} ^ 32'h04C1_1DB7;
        else              c = {c[30:0], 1'b0};
      end
    end
    return c;
  endfunction

  // Monitor: ROM read order, done latency/width and the frame verdict.
  int  ncyc = 0, last_acc = 0, rd_idx = 0;
  logic prev_done = 1'b0;
  exp_t ex;
  always @(negedge clk) begin
    ncyc++;
    if (!rst_n) begin
      rd_idx = 0;
      prev_done = 1'b0;
    end else begin
      if (exp_rd) begin
        check("exp_addr", 64'(exp_addr), 64'(rd_idx));
        rd_idx++;
        if (rd_idx == 8) last_acc = ncyc;
      end
      if (prev_done) check("done_one_cycle", 64'(done), 64'd0);
      if (done) begin
        if (sb.size() == 0) begin
          check("spurious_done", 64'd1, 64'd0);
        end else begin
          ex = sb.pop_front();
          check("rd_count", 64'(rd_idx), 64'd8);
          check("done_latency", 64'(ncyc - last_acc), 64'd3);
          check("busy_at_done", 64'(busy), 64'd0);
          check("pass", 64'(pass), 64'(ex.pass));
          check("err_cnt", 64'(err_cnt), 64'(ex.err));
          check("err_cnt_sat", 64'(s_err_cnt), 64'(ex.err_sat));
          check("first_idx", 64'(fidx), 64'(ex.idx));
          check("first_x", 64'(fx), 64'(ex.x));
          check("first_y", 64'(fy), 64'(ex.y));
          check("first_exp", 64'(fexp), 64'(ex.e));
          check("first_got", 64'(fgot), 64'(ex.g));
          check("crc", 64'(crc), 64'(ex.crc));
          rd_idx = 0;
        end
      end
      prev_done = done;
    end
  end

  // Start a frame and stream n pixels; gaps uses the 1,0,0,1 valid pattern and
  // holds iStart high during the idle cycles (must be ignored while running).
  task automatic run_frame(input logic [15:0] m, input logic [7:0][15:0] p, input int n,
                           input bit gaps, input exp_t e);
    exp_t q;
    int   i, c;
    q = e;
`ifdef FRAME_CRC_EN
    q.crc = crc_model(p, m);
`else
    q.crc = 32'h0;
`endif
    if (n == 8) sb.push_back(q);
    start = 1'b1; mask = m;
    @(posedge clk); #1;
    start = 1'b0; mask = 16'h0000;
    i = 0; c = 0;
    while (i < n) begin
      pix_valid = gaps ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
      start     = gaps && !pix_valid;
      pix_data  = p[i];
      @(posedge clk); #1;
      if (pix_valid) i++;
      c++;
    end
    pix_valid = 1'b0; start = 1'b0; pix_data = 16'h0000;
    if (n == 8) begin
      repeat (6) @(posedge clk);
      #1;
    end
  endtask

  logic [7:0][15:0] good, px;

  initial begin
    rst_n = 1'b0; start = 1'b0; mask = 16'h0000; pix_valid = 1'b0; pix_data = 16'h0000;
    for (int k = 0; k < 8; k++) good[k] = 16'h1000 + 16'(k);
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_pass", 64'(pass), 64'd0);
    check("rst_err", 64'(err_cnt), 64'd0);
    check("rst_ready", 64'(pix_ready), 64'd0);
    check("rst_crc", 64'(crc), 64'd0);
    check("rst_first_idx", 64'(fidx), 64'd0);
    rst_n = 1'b1;
    // valid while idle must not be accepted
    pix_valid = 1'b1; pix_data = 16'h5555;
    repeat (2) @(posedge clk);
    #1;
    check("idle_ready", 64'(pix_ready), 64'd0);
    check("idle_rd", 64'(exp_rd), 64'd0);
    pix_valid = 1'b0;

    // 1: matching frame back-to-back
    run_frame(16'hFFFF, good, 8, 1'b0, mk(1'b1, 17'd0, 2'd0, 17'd0, 17'd0, 17'd0, 16'h0, 16'h0));

    // 2: pixel 5 = DEAD, pixel 7 = 0000
    px = good; px[5] = 16'hDEAD; px[7] = 16'h0000;
    run_frame(16'hFFFF, px, 8, 1'b0, mk(1'b0, 17'd2, 2'd2, 17'd5, 17'd1, 17'd1, 16'h1005, 16'hDEAD));
    repeat (4) @(posedge clk);
    #1;
    check("hold_err", 64'(err_cnt), 64'd2);
    check("hold_pass", 64'(pass), 64'd0);

    // 3: masked low bits differ on pixel 3
    px = good; px[3] = 16'h101F;
    run_frame(16'hFFE0, px, 8, 1'b0, mk(1'b1, 17'd0, 2'd0, 17'd0, 17'd0, 17'd0, 16'h0, 16'h0));

    // 4: stalled stream 1,0,0,1
    run_frame(16'hFFFF, good, 8, 1'b1, mk(1'b1, 17'd0, 2'd0, 17'd0, 17'd0, 17'd0, 16'h0, 16'h0));

    // 5: reset after 4 accepts, then a clean frame
    run_frame(16'hFFFF, good, 4, 1'b0, mk(1'b1, 17'd0, 2'd0, 17'd0, 17'd0, 17'd0, 16'h0, 16'h0));
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_err", 64'(err_cnt), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_frame(16'hFFFF, good, 8, 1'b0, mk(1'b1, 17'd0, 2'd0, 17'd0, 17'd0, 17'd0, 16'h0, 16'h0));

    // 6: every pixel wrong -> saturation in the narrow counter
    for (int k = 0; k < 8; k++) px[k] = 16'hFFFF;
    run_frame(16'hFFFF, px, 8, 1'b0, mk(1'b0, 17'd8, 2'd3, 17'd0, 17'd0, 17'd0, 16'h1000, 16'hFFFF));

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
